// File: rtl/motion_bbox_zones_if.sv
// Pixel stream in, per-zone bounding-box results out.
// master = pixel source / result consumer, slave = motion_bbox_zones.
interface motion_bbox_zones_if #(
  parameter int NUM_ZONES = 4,
  parameter int CW        = 10,
  parameter int CNT_W     = 19
);
  logic                       vsync;
  logic                       href;
  logic                       pix_valid;
  logic                       pix_bin;
  logic                       frame_done;
  logic [NUM_ZONES-1:0]       zone_valid;
  logic [NUM_ZONES*CW-1:0]    x_min_o;
  logic [NUM_ZONES*CW-1:0]    x_max_o;
  logic [NUM_ZONES*CW-1:0]    y_min_o;
  logic [NUM_ZONES*CW-1:0]    y_max_o;
  logic [NUM_ZONES*CNT_W-1:0] pix_cnt_o;
  logic                       line_err;

  modport master (
    output vsync, href, pix_valid, pix_bin,
    input  frame_done, zone_valid, x_min_o, x_max_o, y_min_o, y_max_o, pix_cnt_o, line_err
  );

  modport slave (
    input  vsync, href, pix_valid, pix_bin,
    output frame_done, zone_valid, x_min_o, x_max_o, y_min_o, y_max_o, pix_cnt_o, line_err
  );
endinterface

// File: rtl/motion_bbox_zones.sv
// Per-zone motion bounding boxes over NUM_ZONES equal vertical strips.
// Optional feature: define BBOX_MARGIN_EN to grow each valid box by MARGIN
// pixels on every side at commit (clamped to the image).

// One strip's accumulator plus its commit view (masked / margined box).
module motion_bbox_zone_acc #(
  parameter int CW         = 10,
  parameter int CNT_W      = 19,
  parameter int MIN_PIXELS = 16
`ifdef BBOX_MARGIN_EN
  ,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MARGIN     = 4
`endif
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  output logic             vld,
  output logic [CW-1:0]    xmin,
  output logic [CW-1:0]    xmax,
  output logic [CW-1:0]    ymin,
  output logic [CW-1:0]    ymax,
  output logic [CNT_W-1:0] cnt
);
  logic [CW-1:0]    a_xmin, a_xmax, a_ymin, a_ymax;
  logic [CNT_W-1:0] a_cnt;

  // min/max tracking and saturating foreground count; clear wins over update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_xmin <= '1; a_xmax <= '0; a_ymin <= '1; a_ymax <= '0; a_cnt <= '0;
    end else if (clr) begin
      a_xmin <= '1; a_xmax <= '0; a_ymin <= '1; a_ymax <= '0; a_cnt <= '0;
    end else if (upd) begin
      if (x < a_xmin) a_xmin <= x;
      if (x > a_xmax) a_xmax <= x;
      if (y < a_ymin) a_ymin <= y;
      if (y > a_ymax) a_ymax <= y;
      if (a_cnt != '1) a_cnt <= a_cnt + 1'b1;
    end
  end

  assign vld = (a_cnt >= CNT_W'(MIN_PIXELS));
  assign cnt = a_cnt;

`ifdef BBOX_MARGIN_EN
  localparam logic [CW:0] MG = (CW+1)'(MARGIN);
  localparam logic [CW:0] XL = (CW+1)'(IMG_WIDTH-1);
  localparam logic [CW:0] YL = (CW+1)'(IMG_HEIGHT-1);

  function automatic logic [CW-1:0] grow_lo(input logic [CW-1:0] v);
    grow_lo = ({1'b0, v} >= MG) ? v - MG[CW-1:0] : '0;
  endfunction

  function automatic logic [CW-1:0] grow_hi(input logic [CW-1:0] v, input logic [CW:0] lim);
    grow_hi = (({1'b0, v} + MG) > lim) ? lim[CW-1:0] : v + MG[CW-1:0];
  endfunction

  // commit view: margined box for valid zones, zero otherwise
  always_comb begin
    xmin = '0; xmax = '0; ymin = '0; ymax = '0;
    if (vld) begin
      xmin = grow_lo(a_xmin);
      xmax = grow_hi(a_xmax, XL);
      ymin = grow_lo(a_ymin);
      ymax = grow_hi(a_ymax, YL);
    end
  end
`else
  // commit view: exact box for valid zones, zero otherwise
  always_comb begin
    xmin = '0; xmax = '0; ymin = '0; ymax = '0;
    if (vld) begin
      xmin = a_xmin; xmax = a_xmax; ymin = a_ymin; ymax = a_ymax;
    end
  end
`endif
endmodule

module motion_bbox_zones #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CW         = 10,
  parameter int NUM_ZONES  = 4,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 19,
  parameter int MARGIN     = 4
)(
  input  logic               clk,
  input  logic               rst,
  motion_bbox_zones_if.slave bus
);
  localparam int ZONE_W = IMG_WIDTH / NUM_ZONES;
  localparam int ZIW    = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam logic [CW-1:0]  X_LAST   = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0]  Y_LAST   = CW'(IMG_HEIGHT-1);
  localparam logic [CW-1:0]  COL_LAST = CW'(ZONE_W-1);
  localparam logic [ZIW-1:0] Z_LAST   = ZIW'(NUM_ZONES-1);

  if ((IMG_WIDTH % NUM_ZONES) != 0 || NUM_ZONES < 1 || NUM_ZONES > 8 ||
      MARGIN < 0 || MARGIN >= IMG_WIDTH) begin : g_bad_cfg
    $error("motion_bbox_zones: bad parameter set");
  end

  typedef enum logic [1:0] {S_WAIT, S_FRAME, S_COMMIT} state_t;
  state_t state;

  logic           vs_d, rise_q, href_d;
  logic [CW-1:0]  x_cnt, y_cnt, col;
  logic [ZIW-1:0] zone;
  logic           x_full, line_any, line_err_r;

  logic acc, href_fall, acc_clr;
  assign acc       = bus.href & bus.pix_valid & ~bus.vsync;
  assign href_fall = href_d & ~bus.href;
  // partial first frame is dropped at the first boundary, as is every committed frame
  assign acc_clr   = (state == S_COMMIT) | ((state == S_WAIT) & rise_q);

  // sync edge detection, raster position, zone index and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d <= 1'b0; rise_q <= 1'b0; href_d <= 1'b0;
      x_cnt <= '0; y_cnt <= '0; col <= '0; zone <= '0;
      x_full <= 1'b0; line_any <= 1'b0; line_err_r <= 1'b0;
    end else begin
      vs_d   <= bus.vsync;
      rise_q <= bus.vsync & ~vs_d;
      href_d <= bus.href;
      if (acc) begin
        line_any <= 1'b1;
        if (x_cnt == X_LAST) begin
          // x parks on the last column; any strobe after it fills the line is an overrun
          if (x_full) line_err_r <= 1'b1;
          x_full <= 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            if (zone != Z_LAST) zone <= zone + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end else if (href_fall) begin
        x_cnt <= '0; col <= '0; zone <= '0; x_full <= 1'b0; line_any <= 1'b0;
        if (line_any && y_cnt != Y_LAST) y_cnt <= y_cnt + 1'b1;
      end
      if (rise_q || state == S_COMMIT) y_cnt <= '0;
    end
  end

  logic [NUM_ZONES-1:0]            c_vld;
  logic [NUM_ZONES-1:0][CW-1:0]    c_xmin, c_xmax, c_ymin, c_ymax;
  logic [NUM_ZONES-1:0][CNT_W-1:0] c_cnt;

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    motion_bbox_zone_acc #(
      .CW(CW), .CNT_W(CNT_W), .MIN_PIXELS(MIN_PIXELS)
`ifdef BBOX_MARGIN_EN
      , .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .MARGIN(MARGIN)
`endif
    ) u_acc (
      .clk  (clk),
      .rst  (rst),
      .clr  (acc_clr),
      .upd  (acc & bus.pix_bin & (zone == ZIW'(z))),
      .x    (x_cnt),
      .y    (y_cnt),
      .vld  (c_vld[z]),
      .xmin (c_xmin[z]),
      .xmax (c_xmax[z]),
      .ymin (c_ymin[z]),
      .ymax (c_ymax[z]),
      .cnt  (c_cnt[z])
    );
  end

  logic                            fd_r;
  logic [NUM_ZONES-1:0]            zv_r;
  logic [NUM_ZONES-1:0][CW-1:0]    xmin_r, xmax_r, ymin_r, ymax_r;
  logic [NUM_ZONES-1:0][CNT_W-1:0] cnt_r;

  // frame FSM; results are latched only in S_COMMIT and held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT; fd_r <= 1'b0; zv_r <= '0;
      xmin_r <= '0; xmax_r <= '0; ymin_r <= '0; ymax_r <= '0; cnt_r <= '0;
    end else begin
      fd_r <= 1'b0;
      case (state)
        S_WAIT:  if (rise_q) state <= S_FRAME;
        S_FRAME: if (rise_q) state <= S_COMMIT;
        S_COMMIT: begin
          fd_r   <= 1'b1;
          zv_r   <= c_vld;
          xmin_r <= c_xmin; xmax_r <= c_xmax;
          ymin_r <= c_ymin; ymax_r <= c_ymax;
          cnt_r  <= c_cnt;
          state  <= S_FRAME;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.frame_done = fd_r;
  assign bus.zone_valid = zv_r;
  assign bus.x_min_o    = xmin_r;
  assign bus.x_max_o    = xmax_r;
  assign bus.y_min_o    = ymin_r;
  assign bus.y_max_o    = ymax_r;
  assign bus.pix_cnt_o  = cnt_r;
  assign bus.line_err   = line_err_r;
endmodule

// File: tb/tb_motion_bbox_zones.sv
// Directed bench for motion_bbox_zones: 16x8 image, 4 zones, MIN_PIXELS=2.
module tb_motion_bbox_zones;
  localparam int W = 16, H = 8, NZ = 4, CW = 5, CNT_W = 8, MINP = 2, MG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motion_bbox_zones_if #(.NUM_ZONES(NZ), .CW(CW), .CNT_W(CNT_W)) bus ();

  motion_bbox_zones #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW), .NUM_ZONES(NZ),
    .MIN_PIXELS(MINP), .CNT_W(CNT_W), .MARGIN(MG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] img [H];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NZ*CW-1:0] p5(input int a, input int b, input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  function automatic logic [NZ*CNT_W-1:0] p8(input int a, input int b, input int c, input int d);
    return {CNT_W'(d), CNT_W'(c), CNT_W'(b), CNT_W'(a)};
  endfunction

  // expected box edges for a valid zone, with the optional margin applied
  function automatic int mlo(input int v);
`ifdef BBOX_MARGIN_EN
    return (v >= MG) ? v - MG : 0;
`else
    return v;
`endif
  endfunction

  function automatic int mhi(input int v, input int lim);
`ifdef BBOX_MARGIN_EN
    return (v + MG > lim) ? lim : v + MG;
`else
    return (v > lim) ? lim : v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_line(input logic [31:0] fg, input int n);
    for (int i = 0; i < n; i++) begin
      bus.href = 1'b1; bus.pix_valid = 1'b1; bus.pix_bin = fg[i];
      tick();
    end
    bus.href = 1'b0; bus.pix_valid = 1'b0; bus.pix_bin = 1'b0;
    tick(); tick();
  endtask

  task automatic send_img();
    for (int y = 0; y < H; y++) send_line({16'h0, img[y]}, W);
  endtask

  task automatic clr_img();
    for (int y = 0; y < H; y++) img[y] = '0;
  endtask

  // raise vsync for 12 cycles, count frame_done pulses and their position
  task automatic vsync_edge(input string tag, input bit exp_pulse, input bit stray);
    int n;
    int first;
    n = 0; first = -1;
    bus.vsync = 1'b1;
    if (stray) begin bus.href = 1'b1; bus.pix_valid = 1'b1; bus.pix_bin = 1'b1; end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin bus.href = 1'b0; bus.pix_valid = 1'b0; bus.pix_bin = 1'b0; end
      if (bus.frame_done) begin
        if (first < 0) first = i;
        n++;
      end
    end
    bus.vsync = 1'b0;
    tick(); tick();
    check({tag, "_pulses"}, n, exp_pulse ? 1 : 0);
    if (exp_pulse) check({tag, "_latency"}, first, 2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fd"},   bus.frame_done, 0);
    check({tag, "_zv"},   bus.zone_valid, 0);
    check({tag, "_xmin"}, bus.x_min_o, 0);
    check({tag, "_xmax"}, bus.x_max_o, 0);
    check({tag, "_ymin"}, bus.y_min_o, 0);
    check({tag, "_ymax"}, bus.y_max_o, 0);
    check({tag, "_cnt"},  bus.pix_cnt_o, 0);
    check({tag, "_lerr"}, bus.line_err, 0);
  endtask

  task automatic check_blob(input string tag);
    check({tag, "_zv"},   bus.zone_valid, 4'b0010);
    check({tag, "_xmin"}, bus.x_min_o, p5(0, mlo(5), 0, 0));
    check({tag, "_xmax"}, bus.x_max_o, p5(0, mhi(6, W-1), 0, 0));
    check({tag, "_ymin"}, bus.y_min_o, p5(0, mlo(2), 0, 0));
    check({tag, "_ymax"}, bus.y_max_o, p5(0, mhi(3, H-1), 0, 0));
    check({tag, "_cnt"},  bus.pix_cnt_o, p8(0, 4, 0, 0));
  endtask

  initial begin
    bus.vsync = 1'b0; bus.href = 1'b0; bus.pix_valid = 1'b0; bus.pix_bin = 1'b0;
    clr_img();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    tick();

    // startup: partial first frame is discarded silently
    clr_img(); img[1] = 16'h0600;
    send_img();
    vsync_edge("startup", 1'b0, 1'b0);
    check("startup_zv", bus.zone_valid, 0);
    check("startup_cnt", bus.pix_cnt_o, 0);

    // single blob x=5..6, y=2..3 in zone 1
    clr_img(); img[2] = 16'h0060; img[3] = 16'h0060;
    send_img();
    vsync_edge("blob", 1'b1, 1'b0);
    check_blob("blob");
    check("blob_lerr", bus.line_err, 0);

    // straddle x=3 / x=4 on row 1: each zone below MIN_PIXELS
    clr_img(); img[1] = 16'h0018;
    send_img();
    vsync_edge("straddle", 1'b1, 1'b0);
    check("straddle_zv", bus.zone_valid, 0);
    check("straddle_xmax", bus.x_max_o, 0);
    check("straddle_ymax", bus.y_max_o, 0);
    check("straddle_cnt", bus.pix_cnt_o, p8(1, 1, 0, 0));

    // one pixel at (0,0) plus a foreground strobe coincident with vsync rise
    clr_img(); img[0] = 16'h0001;
    send_img();
    vsync_edge("stray", 1'b1, 1'b1);
    check("stray_zv", bus.zone_valid, 0);
    check("stray_cnt", bus.pix_cnt_o, p8(1, 0, 0, 0));

    // empty frame still pulses
    clr_img();
    send_img();
    vsync_edge("empty", 1'b1, 1'b0);
    check("empty_zv", bus.zone_valid, 0);
    check("empty_xmin", bus.x_min_o, 0);
    check("empty_cnt", bus.pix_cnt_o, 0);

    // over-long line: 18 foreground strobes on row 0
    send_line(32'h0003_FFFF, 18);
    vsync_edge("long", 1'b1, 1'b0);
    check("long_lerr", bus.line_err, 1);
    check("long_zv", bus.zone_valid, 4'b1111);
    check("long_xmin", bus.x_min_o, p5(mlo(0), mlo(4), mlo(8), mlo(12)));
    check("long_xmax", bus.x_max_o, p5(mhi(3, W-1), mhi(7, W-1), mhi(11, W-1), mhi(15, W-1)));
    check("long_ymax", bus.y_max_o, p5(mhi(0, H-1), mhi(0, H-1), mhi(0, H-1), mhi(0, H-1)));
    check("long_cnt", bus.pix_cnt_o, p8(4, 4, 4, 6));

    // reset during line 4
    clr_img(); img[1] = 16'h00F0;
    for (int y = 0; y < 4; y++) send_line({16'h0, img[y]}, W);
    for (int i = 0; i < 5; i++) begin
      bus.href = 1'b1; bus.pix_valid = 1'b1; bus.pix_bin = 1'b1;
      tick();
    end
    rst = 1'b1;
    bus.href = 1'b0; bus.pix_valid = 1'b0; bus.pix_bin = 1'b0;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    send_img();
    vsync_edge("postrst", 1'b0, 1'b0);
    check("postrst_cnt", bus.pix_cnt_o, 0);
    check("postrst_lerr", bus.line_err, 0);
    clr_img(); img[2] = 16'h0060; img[3] = 16'h0060;
    send_img();
    vsync_edge("blob2", 1'b1, 1'b0);
    check_blob("blob2");

`ifdef BBOX_MARGIN_EN
    // blob x=1..2, y=6..7 grows to x 0..6, y 2..7
    clr_img(); img[6] = 16'h0006; img[7] = 16'h0006;
    send_img();
    vsync_edge("margin", 1'b1, 1'b0);
    check("margin_zv", bus.zone_valid, 4'b0001);
    check("margin_xmin", bus.x_min_o, p5(0, 0, 0, 0));
    check("margin_xmax", bus.x_max_o, p5(6, 0, 0, 0));
    check("margin_ymin", bus.y_min_o, p5(2, 0, 0, 0));
    check("margin_ymax", bus.y_max_o, p5(7, 0, 0, 0));
    check("margin_cnt", bus.pix_cnt_o, p8(4, 0, 0, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
